fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter INST_SIZE, default 10: log2 of instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter BRAM_LATENCY, default 1: source-BRAM read latency in cycles, legal range 1..3.
REQ-003 SHALL have parameter TERM_WORD, default 32'h0000_003F: program terminator word.
REQ-004 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 SHALL have port rstn  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port load_start  in  1: one-cycle pulse that starts a program load.
REQ-007 SHALL have port bram_addr  out  INST_SIZE: source-BRAM word address.
REQ-008 SHALL have port bram_dout  in  32: source-BRAM read data.
REQ-009 SHALL have port load_done  out  1: program loaded, fetch enabled.
REQ-010 SHALL have port load_count  out  INST_SIZE+1: number of words stored, terminator included.
REQ-011 SHALL have port load_ovf  out  1: depth was exhausted with no terminator.
REQ-012 SHALL have port fetch_req  in  1: fetch request for pc.
REQ-013 SHALL have port pc  in  32: byte address.
REQ-014 SHALL have port fetch_valid  out  1: inst/fetch_err valid this cycle.
REQ-015 SHALL have port inst  out  32: fetched instruction.
REQ-016 SHALL have port fetch_err  out  1: faulting fetch.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, CAPTURE, DONE.
REQ-018 SHALL, on load_start in IDLE or DONE, clear load_done, load_ovf, load_count and the internal address, then enter ISSUE the next cycle.
REQ-019 SHALL ignore load_start in ISSUE, WAIT and CAPTURE.
REQ-020 SHALL, in ISSUE, drive bram_addr = internal address and enter WAIT.
REQ-021 SHALL hold bram_addr stable in WAIT for exactly BRAM_LATENCY cycles, counted by a latency counter, then enter CAPTURE.
REQ-022 SHALL, in CAPTURE, write bram_dout to memory at the internal address and increment load_count.
REQ-023 SHALL, in CAPTURE, test bram_dout itself (not previously stored memory) against TERM_WORD.
REQ-024 SHALL, in CAPTURE, on a match with TERM_WORD, enter DONE with load_ovf=0.
REQ-025 SHALL, in CAPTURE, with no match and internal address = 2**INST_SIZE-1, enter DONE with load_ovf=1, so load_count = 2**INST_SIZE.
REQ-026 SHALL, in CAPTURE, with no match and address below the top, increment the internal address and return to ISSUE.
REQ-027 SHALL assert load_done only in DONE, registered.
REQ-028 SHALL service fetch_req only when load_done=1, with fetch_valid one cycle after the request (1-cycle latency) and back-to-back requests each cycle allowed.
REQ-029 SHALL compute word index = pc[INST_SIZE+1:2].
REQ-030 SHALL raise fetch_err when pc[1:0]≠0, or pc[31:INST_SIZE+2]≠0, or word index ≥ load_count.
REQ-031 SHALL drive inst = 0 whenever fetch_err=1, and otherwise drive inst = memory[word index].
REQ-032 SHALL drop a fetch_req raised while load_done=0 (fetch_valid stays 0).
REQ-033 SHALL, when load_start and fetch_req coincide in DONE, let load_start win and drop the fetch.
REQ-034 SHALL hold fetch_valid=0 and inst=0 in cycles without a serviced fetch.

Reset
REQ-035 SHALL, on rstn low, immediately force state IDLE, load_done=0, load_ovf=0, load_count=0, bram_addr=0, fetch_valid=0, fetch_err=0, inst=0, and latency counter=0.
REQ-036 SHALL NOT clear memory contents on reset; with load_count=0, no fetch is serviced until a new load completes.
REQ-037 SHALL abort an in-progress load on mid-load reset, with no partial load_done.

Verification
REQ-038 SHALL be verified by: BRAM = {A,B,C,TERM_WORD}, BRAM_LATENCY=1, pulse load_start -> load_done=1, load_count=4, load_ovf=0; fetch pc=0,4,8,12 -> A,B,C,TERM_WORD, each 1 cycle later, fetch_err=0.
REQ-039 SHALL be verified by: same program with BRAM_LATENCY=3 -> bram_addr held 3 cycles per word, identical memory contents, load takes 5 cycles/word.
REQ-040 SHALL be verified by: INST_SIZE=4, BRAM holds no TERM_WORD -> load_done=1, load_ovf=1, load_count=16; fetch pc=60 valid, pc=64 -> fetch_err=1, inst=0.
REQ-041 SHALL be verified by: after 4-word load, fetch pc=2 and pc=16 -> fetch_err=1, inst=0; fetch_req before load_done -> no fetch_valid.
REQ-042 SHALL be verified by: rstn low during word 2 of load -> all outputs at reset values asynchronously; new load_start reloads fully, load_count correct.
REQ-043 SHALL be verified by: load_start and fetch_req in the same cycle in DONE -> fetch_valid stays 0, load_done low next cycle, reload completes.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: loads a program from a source BRAM into local memory, then serves fetches
//   clk, rstn                 clock, asynchronous active-low reset
//   load_start                pulse to (re)load the program
//   bram_addr, bram_dout      source BRAM read port
//   load_done, load_count     load finished / words stored (terminator included)
//   load_ovf                  depth filled without seeing the terminator
//   fetch_req, pc             fetch request by byte address
//   fetch_valid, inst         registered response one cycle after the request
//   fetch_err                 misaligned, out of range, or beyond the loaded program
module fetch_unit #(
  parameter int          INST_SIZE    = 10,
  parameter int          BRAM_LATENCY = 1,
  parameter logic [31:0] TERM_WORD    = 32'h0000_003F
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load_start,
  output logic [INST_SIZE-1:0] bram_addr,
  input  logic [31:0]          bram_dout,
  output logic                 load_done,
  output logic [INST_SIZE:0]   load_count,
  output logic                 load_ovf,
  input  logic                 fetch_req,
  input  logic [31:0]          pc,
  output logic                 fetch_valid,
  output logic [31:0]          inst,
  output logic                 fetch_err
);
  localparam logic [1:0] LAST = 2'(BRAM_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;
  state_t state, nxt;
  logic [INST_SIZE-1:0] addr, idx;
  logic [1:0] lat;
  logic [31:0] mem [2**INST_SIZE];
  logic start, hit, top, svc, err;
  assign start = load_start && (state == IDLE || state == DONE);
  assign hit = bram_dout == TERM_WORD;
  assign top = &addr;
  // load_done is only high in DONE, where a coinciding load_start takes priority
  assign svc = fetch_req && load_done && !load_start;
  assign idx = pc[INST_SIZE+1:2];
  assign err = |pc[1:0] || |(pc >> (INST_SIZE + 2)) || {1'b0, idx} >= load_count;
  assign bram_addr = addr;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = load_start ? ISSUE : state;
      ISSUE:      nxt = WAIT;
      WAIT:       nxt = lat == LAST ? CAPTURE : WAIT;
      CAPTURE:    nxt = hit || top ? DONE : ISSUE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      addr        <= '0;
      lat         <= '0;
      load_done   <= 1'b0;
      load_ovf    <= 1'b0;
      load_count  <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      inst        <= '0;
    end else begin
      if (start) begin
        addr       <= '0;
        load_done  <= 1'b0;
        load_ovf   <= 1'b0;
        load_count <= '0;
      end
      if (state == WAIT) lat <= lat == LAST ? 2'd0 : lat + 2'd1;
      if (state == CAPTURE) begin
        load_count <= load_count + 1'b1;
        if (!hit && !top) addr <= addr + 1'b1;
        if (hit || top) begin
          load_done <= 1'b1;
          load_ovf  <= !hit;
        end
      end
      fetch_valid <= svc;
      fetch_err   <= svc && err;
      inst        <= svc && !err ? mem[idx] : 32'd0;
    end
  // program memory deliberately survives reset; load_count gates its visibility
  always_ff @(posedge clk)
    if (state == CAPTURE) mem[addr] <= bram_dout;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int IS[3] = '{10, 10, 4};
  localparam int LT[3] = '{1, 3, 1};
  localparam logic [31:0] TERM = 32'h0000_003F;
  logic clk = 0, rstn = 0, load_start = 0, fetch_req = 0;
  logic [31:0] pc = 0;
  always #5 clk = ~clk;
  logic [31:0] src [3][1024];
  logic [31:0] dout [3];
  logic [31:0] ins [3];
  logic [9:0] ba [3];
  logic [10:0] lc [3];
  logic [2:0] done, ovf, fv, fe;
  int checks = 0, errors = 0;
  int exp_cnt [3];
  logic exp_ovf [3];
  genvar k;
  generate
    for (k = 0; k < 3; k++) begin : g
      logic [IS[k]-1:0] a;
      logic [IS[k]:0] c;
      logic [31:0] p [3];
      fetch_unit #(.INST_SIZE(IS[k]), .BRAM_LATENCY(LT[k]), .TERM_WORD(TERM)) dut (
        .clk(clk), .rstn(rstn), .load_start(load_start), .bram_addr(a), .bram_dout(dout[k]),
        .load_done(done[k]), .load_count(c), .load_ovf(ovf[k]), .fetch_req(fetch_req), .pc(pc),
        .fetch_valid(fv[k]), .inst(ins[k]), .fetch_err(fe[k]));
      assign ba[k] = 10'(a);
      assign lc[k] = 11'(c);
      always @(posedge clk) begin
        p[0] <= src[k][ba[k]];
        p[1] <= p[0];
        p[2] <= p[1];
      end
      assign dout[k] = p[LT[k]-1];
    end
  endgenerate
  function automatic logic [32:0] model(input int m, input logic [31:0] a);
    logic [31:0] w;
    logic e;
    w = (a >> 2) & ((32'd1 << IS[m]) - 1);
    e = (a[1:0] != 0) || ((a >> (IS[m] + 2)) != 0) || (w >= 32'(exp_cnt[m]));
    return {e, e ? 32'd0 : src[m][w[9:0]]};
  endfunction
  task automatic make_prog(input int m, input int n, input bit term);
    for (int i = 0; i < (1 << IS[m]); i++) begin
      src[m][i] = $urandom;
      if (src[m][i] == TERM) src[m][i] = ~TERM;
    end
    if (term) src[m][n-1] = TERM;
    exp_cnt[m] = term ? n : (1 << IS[m]);
    exp_ovf[m] = !term;
  endtask
  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (done !== 0 || ovf !== 0 || fv !== 0 || fe !== 0) begin
      errors++;
      $display("FAIL reset_flags done=%b ovf=%b valid=%b err=%b expected all 0", done, ovf, fv, fe);
    end
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (lc[m] !== 0 || ba[m] !== 0 || ins[m] !== 0) begin
        errors++;
        $display("FAIL reset_values[%0d] count=%0d addr=%0d inst=%h expected 0", m, lc[m], ba[m], ins[m]);
      end
    end
  endtask
  task automatic test_pre_load;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) fetch_req = 1; pc = 32'(i * 4);
      @(posedge clk); #1;
      checks++;
      if (fv !== 0 || ins[0] !== 0 || ins[1] !== 0 || ins[2] !== 0) begin
        errors++;
        $display("FAIL pre_load_fetch valid=%b inst0=%h expected valid 000 inst 0", fv, ins[0]);
      end
    end
    @(negedge clk) fetch_req = 0;
  endtask
  task automatic do_load(input bit with_fetch);
    int cyc [3];
    logic [2:0] got;
    got = 0;
    cyc = '{-1, -1, -1};
    @(negedge clk) load_start = 1; fetch_req = with_fetch; pc = 0;
    @(negedge clk) load_start = 0; fetch_req = 0;
    checks++;
    if (done !== 0 || fv !== 0) begin
      errors++;
      $display("FAIL load_start_clear done=%b valid=%b expected 000 000", done, fv);
    end
    for (int n = 1; n <= 5000 && got !== 3'b111; n++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 3; m++)
        if (!got[m] && done[m] === 1'b1) begin
          got[m] = 1;
          cyc[m] = n;
        end
    end
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (cyc[m] != exp_cnt[m] * (LT[m] + 2)) begin
        errors++;
        $display("FAIL load_cycles[%0d] got %0d expected %0d", m, cyc[m], exp_cnt[m] * (LT[m] + 2));
      end
      checks++;
      if (lc[m] !== 11'(exp_cnt[m]) || ovf[m] !== exp_ovf[m]) begin
        errors++;
        $display("FAIL load_result[%0d] count=%0d ovf=%b expected %0d %b", m, lc[m], ovf[m], exp_cnt[m], exp_ovf[m]);
      end
    end
  endtask
  task automatic test_fetch_list(input logic [31:0] pcs[$]);
    logic [32:0] r;
    foreach (pcs[i]) begin
      @(negedge clk) fetch_req = 1; pc = pcs[i];
      @(posedge clk); #1;
      for (int m = 0; m < 3; m++) begin
        r = model(m, pcs[i]);
        checks++;
        if (fv[m] !== 1'b1 || fe[m] !== r[32] || ins[m] !== r[31:0]) begin
          errors++;
          $display("FAIL fetch_directed[%0d] pc=%h valid=%b err=%b inst=%h expected 1 %b %h",
                   m, pcs[i], fv[m], fe[m], ins[m], r[32], r[31:0]);
        end
      end
    end
    @(negedge clk) fetch_req = 0;
  endtask
  task automatic test_fetch_random(input int n);
    logic [32:0] r;
    logic [31:0] a;
    logic q;
    for (int i = 0; i < n; i++) begin
      q = ($urandom % 4) != 0;
      case ($urandom % 3)
        0: a = 32'($urandom_range(0, 80)) << 2;
        1: a = 32'($urandom_range(0, 400));
        default: a = $urandom;
      endcase
      @(negedge clk) fetch_req = q; pc = a;
      @(posedge clk); #1;
      for (int m = 0; m < 3; m++) begin
        r = model(m, a);
        checks++;
        if (fv[m] !== q || fe[m] !== (q & r[32]) || ins[m] !== (q ? r[31:0] : 32'd0)) begin
          errors++;
          $display("FAIL fetch_random[%0d] pc=%h req=%b valid=%b err=%b inst=%h expected %b %b %h",
                   m, a, q, fv[m], fe[m], ins[m], q, q & r[32], q ? r[31:0] : 32'd0);
        end
      end
    end
    @(negedge clk) fetch_req = 0;
  endtask
  task automatic fixed_prog;
    for (int m = 0; m < 2; m++) begin
      make_prog(m, 4, 1);
      src[m][0] = 32'hDEAD_BEEF;
      src[m][1] = 32'h1234_5678;
      src[m][2] = 32'hCAFE_F00D;
    end
    make_prog(2, 16, 0);
  endtask
  task automatic test_load_and_boundary;
    logic [31:0] q[$];
    fixed_prog;
    do_load(0);
    q = {32'd0, 32'd4, 32'd8, 32'd12, 32'd2, 32'd16, 32'd60, 32'd64, 32'd13, 32'h1000_0000};
    test_fetch_list(q);
  endtask
  task automatic test_start_vs_fetch;
    logic [31:0] q[$];
    do_load(1);
    q = {32'd0, 32'd8, 32'd60};
    test_fetch_list(q);
  endtask
  task automatic test_midload_reset;
    logic [31:0] q[$];
    int n;
    n = 0;
    @(negedge clk) load_start = 1;
    @(negedge clk) load_start = 0; fetch_req = 1; pc = 0;
    while (ba[0] !== 10'd2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (ba[0] !== 10'd2 || fv !== 0) begin
      errors++;
      $display("FAIL midload_word2 addr=%0d valid=%b expected 2 000", ba[0], fv);
    end
    #2 rstn = 0;
    #1;
    checks++;
    if (done !== 0 || ovf !== 0 || fv !== 0 || fe !== 0) begin
      errors++;
      $display("FAIL async_reset_flags done=%b ovf=%b valid=%b err=%b expected all 0", done, ovf, fv, fe);
    end
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (lc[m] !== 0 || ba[m] !== 0 || ins[m] !== 0) begin
        errors++;
        $display("FAIL async_reset_values[%0d] count=%0d addr=%0d inst=%h expected 0", m, lc[m], ba[m], ins[m]);
      end
    end
    @(negedge clk) rstn = 1; fetch_req = 0;
    test_pre_load;
    do_load(0);
    q = {32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd60};
    test_fetch_list(q);
  endtask
  task automatic test_random_programs;
    for (int i = 0; i < 3; i++) begin
      make_prog(0, $urandom_range(1, 40), 1);
      make_prog(1, $urandom_range(1, 40), 1);
      make_prog(2, $urandom_range(1, 16), 1'($urandom % 2));
      do_load(0);
      test_fetch_random(80);
    end
  endtask
  initial begin
    test_reset;
    @(negedge clk) rstn = 1;
    test_pre_load;
    test_load_and_boundary;
    test_fetch_random(150);
    test_start_vs_fetch;
    test_midload_reset;
    test_random_programs;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
